// File: rtl/fetch_req_scheduler.sv
// I-cache index-port sequencer for the IF stage: issues fetches, bounds in-flight
// requests, tags returns from cancelled paths and slots in CACHE maintenance ops.
module fetch_req_scheduler #(
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned CNT_W   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pcr_req_i,
    output logic       pcr_allowin_o,
    input  logic       cacheop_req_i,
    output logic       cacheop_ack_o,
    input  logic       op_done_i,
    output logic       inst_req_o,
    output logic       inst_op_o,
    input  logic       inst_index_ok_i,
    input  logic       inst_data_ok_i,
    input  logic       cancel_i,
    output logic       drop_o,
    output logic [1:0] state_o,
    output logic       err_o
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] FLUSH  = 2'd1;
    localparam logic [1:0] OPWAIT = 2'd2;
    localparam logic [1:0] OPBUSY = 2'd3;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] kcnt;
    logic [CNT_W-1:0] kcnt_nxt;
    logic             err;
    logic             req;
    logic             op;
    logic             acc;
    logic             dok;
    logic [1:0]       after_kill;

    always_comb begin
        req = 1'b0;
        op  = 1'b0;
        case (state)
            RUN: req = pcr_req_i & (cnt < MAX_CNT) & ~cancel_i & ~cacheop_req_i;
            OPWAIT: begin
                req = (cnt == '0);
                op  = (cnt == '0);
            end
            default: ;
        endcase
    end

    assign acc = req & inst_index_ok_i & ~op;
    assign dok = inst_data_ok_i & (cnt != '0);

    assign cnt_nxt = cnt + CNT_W'(acc) - CNT_W'(dok);

    // A cancel kills everything in flight after this cycle, including a same-cycle accept.
    always_comb begin
        kcnt_nxt = kcnt;
        if (cancel_i) begin
            kcnt_nxt = cnt_nxt;
        end else if (dok && (kcnt != '0)) begin
            kcnt_nxt = kcnt - CNT_W'(1);
        end
    end

    assign after_kill = (kcnt_nxt != '0) ? FLUSH : RUN;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (cancel_i) begin
                    state_nxt = after_kill;
                end else if (cacheop_req_i) begin
                    state_nxt = OPWAIT;
                end
            end
            FLUSH: state_nxt = after_kill;
            OPWAIT: begin
                if (cancel_i) begin
                    state_nxt = after_kill;
                end else if (req && inst_index_ok_i) begin
                    state_nxt = OPBUSY;
                end
            end
            OPBUSY: begin
                if (op_done_i) begin
                    state_nxt = after_kill;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
            kcnt  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            kcnt  <= kcnt_nxt;
            if (inst_data_ok_i && (cnt == '0)) begin
                err <= 1'b1;
            end
        end
    end

    assign inst_req_o    = req & ~rst;
    assign inst_op_o     = op & ~rst;
    assign pcr_allowin_o = acc & ~rst;
    assign drop_o        = inst_data_ok_i & ((kcnt != '0) | cancel_i) & ~rst;
    assign cacheop_ack_o = (state == OPBUSY) & op_done_i & ~rst;
    assign state_o       = state;
    assign err_o         = err;

endmodule

// File: tb/tb_fetch_req_scheduler.sv
// Bench for fetch_req_scheduler: directed vector table, reset corner sequence, and
// random traffic against a queue-based model of in-flight fetches.
module tb_fetch_req_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       pcr_req_i;
    logic       pcr_allowin_o;
    logic       cacheop_req_i;
    logic       cacheop_ack_o;
    logic       op_done_i;
    logic       inst_req_o;
    logic       inst_op_o;
    logic       inst_index_ok_i;
    logic       inst_data_ok_i;
    logic       cancel_i;
    logic       drop_o;
    logic [1:0] state_o;
    logic       err_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    fetch_req_scheduler #(.MAX_OUT(2), .CNT_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .pcr_req_i      (pcr_req_i),
        .pcr_allowin_o  (pcr_allowin_o),
        .cacheop_req_i  (cacheop_req_i),
        .cacheop_ack_o  (cacheop_ack_o),
        .op_done_i      (op_done_i),
        .inst_req_o     (inst_req_o),
        .inst_op_o      (inst_op_o),
        .inst_index_ok_i(inst_index_ok_i),
        .inst_data_ok_i (inst_data_ok_i),
        .cancel_i       (cancel_i),
        .drop_o         (drop_o),
        .state_o        (state_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    // Output bundle: {req, op, allowin, drop, ack, state[1:0], err}
    function automatic logic [7:0] outs();
        return {inst_req_o, inst_op_o, pcr_allowin_o, drop_o, cacheop_ack_o, state_o, err_o};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (req op allow drop ack st st err)", name, got, exp);
        end
    endtask

    task automatic drive(input logic pcr, input logic cop, input logic done,
                         input logic iok, input logic dk, input logic cn);
        pcr_req_i       = pcr;
        cacheop_req_i   = cop;
        op_done_i       = done;
        inst_index_ok_i = iok;
        inst_data_ok_i  = dk;
        cancel_i        = cn;
    endtask

    typedef struct {
        logic       pcr, cop, done, iok, dk, cn;
        logic [7:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic pcr, input logic cop, input logic done,
                                input logic iok, input logic dk, input logic cn,
                                input logic [7:0] exp);
        vec_t v;
        v.pcr = pcr; v.cop = cop; v.done = done; v.iok = iok; v.dk = dk; v.cn = cn;
        v.exp = exp;
        return v;
    endfunction

    // Reference model: in-flight fetches as a queue of "killed" flags, plus a mode number.
    logic kq[$];
    int   mode;
    logic merr;

    task automatic model_reset();
        kq.delete();
        mode = 0;
        merr = 1'b0;
    endtask

    task automatic mstep(input string name, input logic pcr, input logic cop, input logic done,
                         input logic iok, input logic dk, input logic cn,
                         output logic acc_o, output logic ack_o);
        int   n;
        int   nk;
        logic ereq, eop, eacc, edok, edrop, eack;
        drive(pcr, cop, done, iok, dk, cn);
        #1;
        n  = kq.size();
        nk = 0;
        foreach (kq[i]) if (kq[i]) nk++;
        ereq = 1'b0;
        eop  = 1'b0;
        if (mode == 0) ereq = pcr && (n < 2) && !cn && !cop;
        if (mode == 2) begin
            ereq = (n == 0);
            eop  = (n == 0);
        end
        eacc  = ereq && iok && !eop;
        edok  = dk && (n > 0);
        edrop = dk && ((nk > 0) || cn);
        eack  = (mode == 3) && done;
        check(name, outs(), {ereq, eop, eacc, edrop, eack, 2'(mode), merr});
        if (dk && n == 0) merr = 1'b1;
        if (edok) void'(kq.pop_front());
        if (eacc) kq.push_back(1'b0);
        if (cn) foreach (kq[i]) kq[i] = 1'b1;
        nk = 0;
        foreach (kq[i]) if (kq[i]) nk++;
        case (mode)
            0: begin
                if (cn) mode = (nk > 0) ? 1 : 0;
                else if (cop) mode = 2;
            end
            1: mode = (nk > 0) ? 1 : 0;
            2: begin
                if (cn) mode = (nk > 0) ? 1 : 0;
                else if (ereq && iok) mode = 3;
            end
            default: if (done) mode = (nk > 0) ? 1 : 0;
        endcase
        acc_o = eacc;
        ack_o = eack;
    endtask

    vec_t tbl[24];

    initial begin
        logic acc, ack, prev_acc, cop_r;
        logic pcr, iok, dk, cn, done;

        tbl[0]  = mk(1,0,0,1,0,0, 8'b1010_0000);
        tbl[1]  = mk(1,0,0,1,0,0, 8'b1010_0000);
        tbl[2]  = mk(1,0,0,1,0,0, 8'b0000_0000);
        tbl[3]  = mk(1,0,0,1,1,0, 8'b0000_0000);
        tbl[4]  = mk(1,0,0,1,0,0, 8'b1010_0000);
        tbl[5]  = mk(0,0,0,1,0,1, 8'b0000_0000);
        tbl[6]  = mk(0,0,0,0,1,0, 8'b0001_0010);
        tbl[7]  = mk(1,0,0,1,1,0, 8'b0001_0010);
        tbl[8]  = mk(1,0,0,1,0,0, 8'b1010_0000);
        tbl[9]  = mk(0,0,0,0,1,0, 8'b0000_0000);
        tbl[10] = mk(1,0,0,1,0,0, 8'b1010_0000);
        tbl[11] = mk(1,0,0,1,1,1, 8'b0001_0000);
        tbl[12] = mk(1,0,0,1,0,0, 8'b1010_0000);
        tbl[13] = mk(0,0,0,0,1,0, 8'b0000_0000);
        tbl[14] = mk(1,0,0,1,0,0, 8'b1010_0000);
        tbl[15] = mk(1,0,0,1,0,0, 8'b1010_0000);
        tbl[16] = mk(1,1,0,1,0,0, 8'b0000_0000);
        tbl[17] = mk(1,1,0,1,1,0, 8'b0000_0100);
        tbl[18] = mk(1,1,0,1,1,0, 8'b0000_0100);
        tbl[19] = mk(1,1,0,0,0,0, 8'b1100_0100);
        tbl[20] = mk(1,1,0,1,0,0, 8'b1100_0100);
        tbl[21] = mk(1,1,0,1,0,0, 8'b0000_0110);
        tbl[22] = mk(1,1,1,1,0,0, 8'b0000_1110);
        tbl[23] = mk(1,0,0,1,0,0, 8'b1010_0000);

        drive(0,0,0,0,0,0);
        rst = 1'b1;
        #1;
        check("reset_outputs", outs(), 8'b0000_0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int unsigned i = 0; i < 24; i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i].pcr, tbl[i].cop, tbl[i].done, tbl[i].iok, tbl[i].dk, tbl[i].cn);
            #1;
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // One fetch in flight; cancel leaves kcnt=1 in FLUSH, then reset lands mid-FLUSH.
        @(negedge clk);
        drive(0,0,0,0,0,1);
        #1;
        check("rst_seq_cancel", outs(), 8'b0000_0000);
        @(negedge clk);
        drive(0,0,0,0,0,0);
        #1;
        check("rst_seq_flush", outs(), 8'b0000_0010);
        @(negedge clk);
        drive(1,1,0,1,1,0);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", outs(), 8'b0000_0000);
        @(negedge clk);
        rst = 1'b0;
        drive(0,0,0,0,1,0);
        #1;
        check("late_dok_not_dropped", outs(), 8'b0000_0000);
        @(negedge clk);
        drive(1,0,0,1,0,0);
        #1;
        check("late_dok_sets_err", outs(), 8'b1010_0001);

        // Model-checked phases start from a fresh reset.
        @(negedge clk);
        drive(0,0,0,0,0,0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Return one cycle after each accept: one accept per cycle in steady state.
        prev_acc = 1'b0;
        for (int unsigned i = 0; i < 30; i++) begin
            @(negedge clk);
            mstep("steady", 1, 0, 0, 1, prev_acc, 0, acc, ack);
            check("steady_accept", {7'b0, pcr_allowin_o}, 8'b0000_0001);
            prev_acc = acc;
        end
        @(negedge clk);
        mstep("steady_drain", 0, 0, 0, 0, prev_acc, 0, acc, ack);

        cop_r = 1'b0;
        for (int unsigned i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!cop_r && ($urandom_range(15) == 0)) cop_r = 1'b1;
            pcr  = ($urandom_range(3) != 0);
            iok  = ($urandom_range(3) != 0);
            dk   = (kq.size() > 0) && ($urandom_range(1) == 1);
            cn   = ($urandom_range(11) == 0);
            done = (mode == 3) && ($urandom_range(2) == 0);
            if (cn && mode >= 2) begin
                iok  = 1'b0;
                done = 1'b0;
            end
            mstep("random", pcr, cop_r, done, iok, dk, cn, acc, ack);
            if (ack || cn) cop_r = 1'b0;
        end

        @(negedge clk);
        drive(0,0,0,0,0,0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
